// File: rtl/scaler_out_pack.sv
// Rounds/saturates scaler core results to 8-bit pixels, packs PIX_PER_BEAT per beat
// and buffers beats in a show-ahead FIFO feeding an AXI-Stream master.

module scaler_out_pack_lane (
  input  logic       core_clk,
  input  logic       core_rst_n,
  input  logic       wr,
  input  logic       clr,
  input  logic [7:0] pix,
  output logic [7:0] cur_byte,
  output logic       cur_keep
);
  logic [7:0] byte_q;
  logic       keep_q;

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      byte_q <= '0;
      keep_q <= 1'b0;
    end else if (clr) begin
      byte_q <= '0;
      keep_q <= 1'b0;
    end else if (wr) begin
      byte_q <= pix;
      keep_q <= 1'b1;
    end
  end

  // Closing beat sees the pixel arriving this cycle.
  assign cur_byte = wr ? pix : byte_q;
  assign cur_keep = wr | keep_q;
endmodule

module scaler_out_pack #(
  parameter int IN_W         = 16,
  parameter int FRAC_BITS    = 7,
  parameter int PIX_PER_BEAT = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_THRESH = 12
) (
  input  logic                      core_clk,
  input  logic                      core_rst_n,
  input  logic                      s_axis_core_valid,
  input  logic [IN_W-1:0]           s_axis_core_data,
  input  logic                      s_axis_core_done,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [8*PIX_PER_BEAT-1:0] m_axis_tdata,
  output logic [PIX_PER_BEAT-1:0]   m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic                      core_afull,
  output logic                      err_overflow
);
  localparam int LW = (PIX_PER_BEAT > 1) ? $clog2(PIX_PER_BEAT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [IN_W:0] HALF = (IN_W+1)'(1) << (FRAC_BITS - 1);

  typedef struct packed {
    logic                               last;
    logic [PIX_PER_BEAT-1:0]            keep;
    logic [PIX_PER_BEAT-1:0][7:0]       data;
  } beat_t;

  // Stage 1: round half-up at IN_W+1 bits, then saturate to [0,255]
  logic signed [IN_W:0] sum, y;
  logic [7:0]           pix_d, pix1;
  logic                 vld1, done1;

  assign sum   = $signed({s_axis_core_data[IN_W-1], s_axis_core_data}) + $signed(HALF);
  assign y     = sum >>> FRAC_BITS;
  assign pix_d = y[IN_W] ? 8'd0 : (|y[IN_W-1:8]) ? 8'hFF : y[7:0];

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      pix1  <= '0;
      vld1  <= 1'b0;
      done1 <= 1'b0;
    end else begin
      pix1  <= pix_d;
      vld1  <= s_axis_core_valid;
      done1 <= s_axis_core_done;
    end
  end

  // Stage 2: packer
  logic [LW-1:0]                  lane;
  logic                           close;
  logic [PIX_PER_BEAT-1:0]        lane_wr;
  logic [PIX_PER_BEAT-1:0][7:0]   cur_data;
  logic [PIX_PER_BEAT-1:0]        cur_keep;

  assign close = (vld1 && lane == LW'(PIX_PER_BEAT-1)) || done1;

  for (genvar i = 0; i < PIX_PER_BEAT; i++) begin : g_lane
    assign lane_wr[i] = vld1 && lane == LW'(i);
    scaler_out_pack_lane u_lane (
      .core_clk   (core_clk),
      .core_rst_n (core_rst_n),
      .wr         (lane_wr[i]),
      .clr        (close),
      .pix        (pix1),
      .cur_byte   (cur_data[i]),
      .cur_keep   (cur_keep[i])
    );
  end

  beat_t push_beat;
  logic  push_vld;

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      lane      <= '0;
      push_vld  <= 1'b0;
      push_beat <= '0;
    end else begin
      push_vld <= close;
      if (close) begin
        lane      <= '0;
        push_beat <= {done1, cur_keep, cur_data};
      end else if (vld1) begin
        lane <= lane + LW'(1);
      end
    end
  end

  // Beat FIFO, show-ahead
  beat_t          mem [FIFO_DEPTH];
  beat_t          head;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           empty, full, pop, push_ok;

  assign empty   = cnt == '0;
  assign full    = cnt == CW'(FIFO_DEPTH);
  assign pop     = !empty && m_axis_tready;
  assign push_ok = push_vld && (!full || pop);
  assign cnt_nxt = cnt + CW'(push_ok) - CW'(pop);

  always_ff @(posedge core_clk) begin
    if (push_ok) mem[wr_ptr] <= push_beat;
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      core_afull   <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      cnt          <= cnt_nxt;
      core_afull   <= cnt_nxt >= CW'(AFULL_THRESH);
      err_overflow <= err_overflow | (push_vld & ~push_ok);
    end
  end

  // Gate with empty so outputs read 0 out of reset despite unreset storage.
  assign head          = empty ? '0 : mem[rd_ptr];
  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = head.data;
  assign m_axis_tkeep  = head.keep;
  assign m_axis_tlast  = head.last;
endmodule

// File: tb/tb_scaler_out_pack.sv
// Randomized bench for scaler_out_pack with a pixel-list reference model and scoreboard.

module tb_scaler_out_pack;
  localparam int P = 4;

  logic        core_clk = 1'b0;
  logic        core_rst_n = 1'b0;
  logic        valid = 1'b0, done = 1'b0, tready = 1'b0;
  logic [15:0] data = '0;
  logic        m_axis_tvalid, m_axis_tlast, core_afull, err_overflow;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;

  scaler_out_pack dut (
    .core_clk          (core_clk),
    .core_rst_n        (core_rst_n),
    .s_axis_core_valid (valid),
    .s_axis_core_data  (data),
    .s_axis_core_done  (done),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (tready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tkeep      (m_axis_tkeep),
    .m_axis_tlast      (m_axis_tlast),
    .core_afull        (core_afull),
    .err_overflow      (err_overflow)
  );

  always #5 core_clk = ~core_clk;

  int checks = 0, errors = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: pixels collected into a list, emitted as {last,keep,data} beats
  logic [36:0] exp_q[$];
  int          pix_buf[P];
  int          n_buf = 0;

  function automatic int to_pix(int x);
    int r;
    r = (x + 64) >>> 7;
    if (r < 0)   r = 0;
    if (r > 255) r = 255;
    return r;
  endfunction

  task automatic model_in(bit v, int x, bit d);
    logic [31:0] dd;
    logic [3:0]  kk;
    if (v) begin
      pix_buf[n_buf] = to_pix(x);
      n_buf++;
    end
    if (n_buf == P || d) begin
      dd = '0;
      kk = '0;
      for (int i = 0; i < n_buf; i++) begin
        dd[8*i +: 8] = 8'(pix_buf[i]);
        kk[i]        = 1'b1;
      end
      exp_q.push_back({d, kk, dd});
      n_buf = 0;
    end
  endtask

  task automatic send(bit v, int x, bit d);
    @(posedge core_clk); #1;
    valid = v;
    data  = x[15:0];
    done  = d;
    model_in(v, x, d);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge core_clk); #1;
      valid = 1'b0;
      done  = 1'b0;
    end
  endtask

  task automatic send_beat(int base);
    for (int i = 0; i < P; i++) send(1, ((base + i) % 256) * 128, 0);
  endtask

  // tready: 0 = hold off, 1 = always ready, 2 = random 50%
  int rdy_mode = 1;
  initial forever begin
    @(posedge core_clk); #1;
    tready = (rdy_mode == 2) ? 1'($urandom % 2) : (rdy_mode == 1);
  end

  // Output monitor: scoreboard, stall stability, afull during drain
  bit          drain = 0;
  int          npop = 0;
  bit          stall_prev = 0;
  logic [36:0] prev_beat = '0;
  initial forever begin
    @(negedge core_clk);
    if (core_rst_n) begin
      if (drain) chk("afull_drain", core_afull, (16 - npop) >= 12);
      if (stall_prev)
        chk("stall_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, {1'b1, prev_beat});
      if (m_axis_tvalid && tready) begin
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else chk("beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, exp_q.pop_front());
        npop++;
      end
      stall_prev = m_axis_tvalid && !tready;
      prev_beat  = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    end else begin
      stall_prev = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge core_clk);
    @(negedge core_clk);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata",  m_axis_tdata, 0);
    chk("rst_tkeep",  m_axis_tkeep, 0);
    chk("rst_tlast",  m_axis_tlast, 0);
    chk("rst_afull",  core_afull, 0);
    chk("rst_err",    err_overflow, 0);
    @(posedge core_clk); #1;
    core_rst_n = 1'b1;
    idle(2);

    // Rounding/saturation and latency
    send(1, 128, 0); send(1, 256, 0); send(1, -50, 0); send(1, 32767, 0);
    idle(1);
    @(negedge core_clk); chk("lat_n1", m_axis_tvalid, 0);
    @(negedge core_clk); chk("lat_n2", m_axis_tvalid, 0);
    @(negedge core_clk); chk("lat_n3", m_axis_tvalid, 1);
    chk("t1_data", m_axis_tdata, 32'hFF000201);
    chk("t1_keep", m_axis_tkeep, 4'hF);
    chk("t1_last", m_axis_tlast, 0);
    idle(4);

    // Partial beat closed by done on the pixel
    for (int k = 1; k <= 6; k++) send(1, 128 * k, k == 6);
    idle(8);

    // Lone done with empty packer
    send(0, 0, 1);
    idle(6);
    chk("t3_left", exp_q.size(), 0);

    // Overflow with tready held low
    rdy_mode = 0;
    idle(2);
    for (int b = 0; b < 11; b++) send_beat(4 * b);
    idle(5);
    chk("afull_11", core_afull, 0);
    send_beat(44);
    idle(5);
    chk("afull_12", core_afull, 1);
    chk("err_pre", err_overflow, 0);
    for (int b = 12; b < 20; b++) send_beat(4 * b);
    idle(5);
    chk("err_ovf", err_overflow, 1);
    chk("ovf_tvalid", m_axis_tvalid, 1);
    repeat (4) void'(exp_q.pop_back());
    npop = 0;
    drain = 1;
    rdy_mode = 1;
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge core_clk);
    chk("drain_left", exp_q.size(), 0);
    idle(3);
    chk("drain_npop", npop, 16);
    chk("drain_empty", m_axis_tvalid, 0);
    drain = 0;

    // Reset mid-line discards partial beat and clears sticky error
    send(1, 128, 0); send(1, 256, 0);
    @(posedge core_clk); #1;
    valid = 1'b0;
    core_rst_n = 1'b0;
    n_buf = 0;
    exp_q.delete();
    repeat (3) begin
      @(negedge core_clk);
      chk("mrst_tvalid", m_axis_tvalid, 0);
      chk("mrst_err", err_overflow, 0);
    end
    @(posedge core_clk); #1;
    core_rst_n = 1'b1;
    for (int k = 5; k <= 8; k++) send(1, 128 * k, 0);
    idle(1);
    chk("mrst_model", exp_q[0], {1'b0, 4'hF, 32'h08070605});
    idle(6);
    chk("mrst_left", exp_q.size(), 0);

    // Random ready, incrementing pattern with random fractions, gaps and dones
    rdy_mode = 2;
    for (int k = 0; k < 400; k++) begin
      if ($urandom % 8 == 0) send(0, 0, 0);
      send(1, (k % 256) * 128 + int'($urandom_range(0, 127)) - 64, ($urandom % 37) == 0);
    end
    idle(1);
    rdy_mode = 1;
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(posedge core_clk);
    chk("rand_left", exp_q.size(), 0);
    idle(3);
    chk("rand_err", err_overflow, 0);
    chk("rand_empty", m_axis_tvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scaler_out_pack.md
Name: scaler_out_pack

Overview:
Downstream stage of scaler_dsp. It consumes the core result stream (m_axis_core_valid/data/done) and rounds each fixed-point result to an 8-bit pixel with saturation. It packs PIX_PER_BEAT pixels per beat into an AXI-Stream master, buffered by a small FIFO. The core has no ready input, so the block raises core_afull to let the upstream scheduler throttle, and flags any overflow.

Parameters:
IN_W, 16, width of signed core result
FRAC_BITS, 7, fractional bits of core result (coefficient unity = 128)
PIX_PER_BEAT, 4, pixels packed per output beat
FIFO_DEPTH, 16, beat FIFO depth (power of 2)
AFULL_THRESH, 12, fill level at or above which core_afull asserts

Ports:
core_clk  in  1  sole clock
core_rst_n  in  1  reset, asynchronous, active-low
s_axis_core_valid  in  1  result valid, no backpressure
s_axis_core_data  in  IN_W  signed fixed-point result
s_axis_core_done  in  1  end-of-line pulse
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  downstream ready
m_axis_tdata  out  8*PIX_PER_BEAT  packed pixels, pixel 0 in LSB byte
m_axis_tkeep  out  PIX_PER_BEAT  per-pixel byte enable
m_axis_tlast  out  1  last beat of line
core_afull  out  1  FIFO fill >= AFULL_THRESH
err_overflow  out  1  sticky: beat dropped on full FIFO

Behaviour:
- Interface: one clock (core_clk); reset (core_rst_n) is asynchronous and active-low.
- Reset state: all outputs 0, FIFO empty, lane counter 0, packer register cleared, err_overflow cleared.
- Stage 1 (registered, 1 cycle):
  - Compute y = (x + 2^(FRAC_BITS-1)) >>> FRAC_BITS at IN_W+1 bits so the rounding add cannot overflow.
  - Clamp: y<0 gives 0; y>255 gives 255.
  - valid and done are delayed alongside the data.
- Stage 2 packer, lane counter 0..PIX_PER_BEAT-1:
  - A valid pixel writes byte[lane] and sets keep[lane]; lane increments.
  - The beat closes when lane = PIX_PER_BEAT-1 with valid, or when done is seen.
  - Closed beat: tkeep = filled lanes. tlast = 1 if done is in the same cycle as the closing pixel, or done closed a partial beat. Lane resets to 0 and the packer register clears.
  - Done with valid in the same cycle: that pixel is included first, then the beat closes with tlast.
  - Done with lane 0 and no valid: push a beat with tkeep=0, tdata=0, tlast=1.
  - Unfilled bytes of a partial beat are 0.
- FIFO push (one cycle after close):
  - Accepted if not full, or if full with a pop in the same cycle.
  - Otherwise the beat is dropped and err_overflow=1 until reset.
- FIFO output (show-ahead):
  - tvalid = !empty.
  - Pop on tvalid & tready.
  - tdata, tkeep and tlast are held stable while tvalid & !tready.
- Latency: closing pixel at input cycle N gives tvalid at N+3 when the FIFO is empty.
- Throughput: one pixel per cycle in, one beat per cycle out.
- core_afull is registered from fill count and updates the cycle after push or pop.
- Reset mid-line discards the partial beat and all FIFO contents; no tlast is emitted for the aborted line.

Test Plan:
- Inputs 128, 256, -50, 32767 back-to-back -> one beat: tdata=0xFF000201, tkeep=0xF, tlast=0, tvalid 3 cycles after the 4th input.
- Inputs 128·k for k=1..6, done with the 6th -> beat 0x04030201/keep 0xF/last 0, then beat 0x00000605/keep 0x3/last 1.
- Done pulse alone with lane 0 -> single beat: tdata=0, tkeep=0x0, tlast=1.
- tready=0, push 20 full beats -> core_afull=1 after the 12th is stored, 16 beats held, err_overflow=1. Then tready=1 drains exactly 16 beats in order; core_afull falls when fill <12.
- Random tready (50%) over 100 beats of an incrementing pattern -> no loss or duplication; tdata stable on every stalled cycle.
- 2 valid pixels, then core_rst_n low for 3 cycles -> tvalid=0, err_overflow=0. After release, the next 4 pixels form a fresh full beat with no residue.
